shift_sched: RTL

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched_pkg.sv | 17 +
 rtl/shift_sched_arb.sv | 43 ++++
 rtl/shift_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types for the shift scheduler: FSM state encoding, requester ID and operand type.
package pkg_system_mdr;

    localparam int unsigned DataWidth = 32;

    typedef logic [DataWidth-1:0] data_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } shift_sched_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/shift_sched_arb.sv
// Two-way arbiter for shift_sched. SHIFT_SCHED_RR_EN selects round-robin, otherwise
// requester 0 has fixed priority.
module shift_sched_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       accept,
    output logic [1:0] gnt
);

`ifdef SHIFT_SCHED_RR_EN
    // ID of the requester granted most recently; resets to 1 so requester 0 wins first
    logic last_q, last_d;

    always_comb begin
        gnt = {req1, req0};
        if (req0 && req1) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (accept) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, accept};

    always_comb begin
        gnt = {req1 & ~req0, req0};
    end
`endif

endmodule

// File: rtl/shift_sched.sv
// Schedules single-step operations from two requesters onto an external registered shift unit.
// Arbitration policy is set by SHIFT_SCHED_RR_EN (see shift_sched_arb).
module shift_sched
    import pkg_system_mdr::*;
#(
    parameter int unsigned DW = DataWidth,
    parameter int unsigned CW = $clog2(DW) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [DW-1:0] req0_data,
    input  logic [DW-1:0] req1_data,
    input  logic [CW-1:0] req0_cnt,
    input  logic [CW-1:0] req1_cnt,
    output logic [DW-1:0] o_sh_val,
    output logic          o_sh_enable,
    input  logic [DW-1:0] i_sh_val,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_id,
    output logic          o_busy,
    input  logic          i_ready
);

    shift_sched_state_e state_q, state_d;
    logic [DW-1:0]      work_q, work_d;
    logic [CW-1:0]      rem_q, rem_d;
    req_id_t            id_q, id_d;

    logic [1:0]    gnt;
    logic          accept;
    logic [CW-1:0] cnt_sel;
    logic [CW-1:0] cnt_clamped;

    shift_sched_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .accept (accept),
        .gnt    (gnt)
    );

    // Ready is masked by rst so nothing looks accepted while reset is held
    assign accept      = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
    assign cnt_sel     = gnt[1] ? req1_cnt : req0_cnt;
    assign cnt_clamped = (cnt_sel > CW'(DW)) ? CW'(DW) : cnt_sel;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        id_d    = id_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    id_d    = gnt[1];
                    work_d  = gnt[1] ? req1_data : req0_data;
                    rem_d   = cnt_clamped;
                    state_d = (cnt_clamped != '0) ? StIssue : StDone;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                work_d  = i_sh_val;
                rem_d   = rem_q - CW'(1);
                state_d = (rem_q == CW'(1)) ? StDone : StIssue;
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            rem_q   <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        req0_ready  = accept && gnt[0];
        req1_ready  = accept && gnt[1];
        o_sh_enable = (state_q == StIssue);
        o_sh_val    = work_q;
        o_valid     = (state_q == StDone);
        o_data      = work_q;
        o_id        = id_q;
        o_busy      = (state_q != StIdle);
    end

endmodule
